store_buffer: RTL and testbench
===============================

# store_buffer

Posted write buffer between the pipelined core's memory stage and the data memory. It accepts word stores from the M stage (`mem_write`, `data_addr_m`, `write_data_m`) into a FIFO and drains them to memory over a valid/ready request port. It forwards buffered data to M-stage loads whose address matches, and stalls the pipeline when full. It is the consuming end of the store interface that the core drives.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; power of two, at least 2.
- `AW`, default 32: address width.
- `DW`, default 32: data width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_write`  in  1  M-stage store strobe.
- `data_addr_m`  in  AW  M-stage address, shared by stores and loads.
- `write_data_m`  in  DW  M-stage store data.
- `mem_read`  in  1  M-stage load strobe; never asserted together with `mem_write`.
- `fwd_hit`  out  1  load address matches a buffered entry.
- `fwd_data`  out  DW  data of the youngest matching entry.
- `stall_m`  out  1  buffer full; the core holds its M stage.
- `mem_req_valid`  out  1  a drain request is presented.
- `mem_req_addr`  out  AW  head entry address.
- `mem_req_data`  out  DW  head entry data.
- `mem_req_ready`  in  1  memory accepts the request.
- `empty`  out  1  no entries buffered; used as a fence/drain indicator.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- **Storage:** circular FIFO built from `head` and `tail` pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a `count` register. Each entry holds an address and data.
- **Enqueue:** occurs when `mem_write && !full`. The entry is written at `tail`, `tail` increments, and `count` increments.
- **Dequeue:** occurs when `mem_req_valid && mem_req_ready`. `head` increments and `count` decrements.
- **Simultaneous enqueue and dequeue:** both pointers advance and `count` is unchanged.
- **Full:** `full = (count == DEPTH)`. While full, enqueue is blocked even if a dequeue happens in the same cycle. The core retries the store next cycle with `stall_m` deasserted.
- **Outputs:**
  - `stall_m = mem_write && full`, combinational.
  - `mem_req_valid = (count != 0)`.
  - `mem_req_addr` and `mem_req_data` come from the entry at `head`.
- **Request stability:** while `mem_req_valid && !mem_req_ready`, the request fields stay stable. They change only after a handshake.
- **Forwarding:**
  - Combinational. When `mem_read` is high, compare `data_addr_m[AW-1:2]` against every valid entry.
  - `fwd_hit = 1` if any entry matches. `fwd_data` comes from the youngest match, i.e. the one closest to `tail`.
  - An entry being dequeued this cycle still counts as a match this cycle.
  - When `mem_read` is 0 or there is no match, `fwd_hit = 0` and `fwd_data = 0`.
- **Address handling:** stores are full words only. Address bits [1:0] are stored unchanged but ignored in matching.
- **No coalescing:** two stores to the same address occupy two entries and drain in program order.
- **Reset:** `head = 0`, `tail = 0`, `count = 0`. Entry contents are don't-care. Reset mid-drain discards all pending entries; no request is issued in the cycle after reset.

## Timing
- Reset values:
  - `count = 0`, `empty = 1`
  - `mem_req_valid = 0`, `mem_req_addr = 0`, `mem_req_data = 0`. Request fields are forced to 0 while empty.
  - `stall_m = 0` and `fwd_hit = 0` in the absence of inputs.
  - `fwd_data = 0`.
- **Enqueue-to-request latency:** 1 cycle. A store accepted at edge N appears on `mem_req_*` with `mem_req_valid = 1` after edge N, when the buffer was previously empty.
- **Throughput:** one enqueue and one dequeue per cycle, sustained.
- **Forwarding timing:** a store enqueued at edge N is forwardable to a load presented in the cycle after edge N. Loads in the same cycle as the store do not occur.
- **Wrap-around:** pointers wrap from DEPTH-1 to 0 with no bubble.
- **Handshake:** `mem_req_ready` may be high while `mem_req_valid` is low; this has no effect.
- **Stall clearing:** `stall_m` drops in the cycle after the first dequeue that follows full.

## Test plan
- **Single store:** reset, then store data 25 to address 100 with `mem_req_ready = 1`. Next cycle: `mem_req_valid = 1`, addr 100, data 25. One cycle later: `empty = 1`.
- **Fill and stall:** hold `mem_req_ready = 0` and issue 5 stores, addresses 0, 4, 8, 12, 16 with data 1–5.
  - After 4 stores: `count = 4`, and `stall_m = 1` while the 5th is presented.
  - Raise ready for one cycle: addr 0 drains, the store to 16 is accepted next cycle, and `count` stays 4.
- **Forwarding youngest:** ready = 0; store 7 to address 96, then store 9 to address 96. A load of address 96 gives `fwd_hit = 1`, `fwd_data = 9`. A load of address 97 also hits (bits [1:0] ignored). A load of address 100 gives `fwd_hit = 0`.
- **Simultaneous enqueue and dequeue with wrap:** ready = 1 and 10 back-to-back stores. `count` stays 1 throughout, and requests appear in order with no bubbles across the pointer wrap.
- **Backpressure stability:** ready = 0 for 5 cycles with one entry. `mem_req_addr` and `mem_req_data` stay constant. Ready = 1 for one cycle gives exactly one handshake.
- **Reset mid-operation:** three entries buffered, then assert `rst` for one cycle. Afterwards: `count = 0`, `mem_req_valid = 0`, and a load of a previously stored address gives `fwd_hit = 0`.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: posted word-store FIFO with youngest-match load forwarding and full stall
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_write,
    input  logic [AW-1:0]            data_addr_m,
    input  logic [DW-1:0]            write_data_m,
    input  logic                     mem_read,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_data,
    output logic                     stall_m,
    output logic                     mem_req_valid,
    output logic [AW-1:0]            mem_req_addr,
    output logic [DW-1:0]            mem_req_data,
    input  logic                     mem_req_ready,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          full, enq, deq;

    assign full          = count_q == (PW+1)'(DEPTH);
    assign enq           = mem_write && !full;
    assign deq           = mem_req_valid && mem_req_ready;
    assign stall_m       = mem_write && full;
    assign mem_req_valid = count_q != '0;
    assign empty         = count_q == '0;
    assign count         = count_q;
    assign mem_req_addr  = mem_req_valid ? addr_q[head_q] : '0;
    assign mem_req_data  = mem_req_valid ? data_q[head_q] : '0;

    // Pointer and occupancy next state; pointers wrap naturally at DEPTH
    always_comb begin
        head_d  = deq ? head_q + PW'(1) : head_q;
        tail_d  = enq ? tail_q + PW'(1) : tail_q;
        count_d = (enq && !deq) ? count_q + (PW+1)'(1) :
                  (!enq && deq) ? count_q - (PW+1)'(1) : count_q;
    end

    // Walk entries oldest to youngest so the last match (youngest) wins
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_read && (PW+1)'(i) < count_q &&
                addr_q[head_q + PW'(i)][AW-1:2] == data_addr_m[AW-1:2]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[head_q + PW'(i)];
            end
        end
    end

    // Entry storage needs no reset; validity comes from head/count
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= data_addr_m;
            data_q[tail_q] <= write_data_m;
        end
    end

    // Control state; reset discards every pending entry
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random checks of store_buffer against a queue model
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_write, mem_read, mem_req_ready;
    logic [31:0]   data_addr_m, write_data_m;
    logic          fwd_hit, stall_m, mem_req_valid, empty;
    logic [31:0]   fwd_data, mem_req_addr, mem_req_data;
    logic [CW-1:0] count;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] qa[$];
    logic [31:0] qd[$];
    logic [31:0] held_a, held_d;

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst), .mem_write(mem_write), .data_addr_m(data_addr_m),
        .write_data_m(write_data_m), .mem_read(mem_read), .fwd_hit(fwd_hit),
        .fwd_data(fwd_data), .stall_m(stall_m), .mem_req_valid(mem_req_valid),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_ready(mem_req_ready), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one cycle of inputs and compare every output with the model
    task automatic drive(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy);
        int n;
        logic efh;
        logic [31:0] efd;
        mem_write = w; mem_read = r; data_addr_m = a; write_data_m = d; mem_req_ready = rdy;
        #1;
        n = qa.size();
        efh = 1'b0; efd = '0;
        if (r)
            for (int i = 0; i < n; i++)
                if (qa[i][31:2] == a[31:2]) begin efh = 1'b1; efd = qd[i]; end
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("req_valid", 32'(mem_req_valid), 32'(n != 0));
        chk("req_addr", mem_req_addr, n != 0 ? qa[0] : 32'h0);
        chk("req_data", mem_req_data, n != 0 ? qd[0] : 32'h0);
        chk("stall_m", 32'(stall_m), 32'(w && n == DEPTH));
        chk("fwd_hit", 32'(fwd_hit), 32'(efh));
        chk("fwd_data", fwd_data, efd);
    endtask

    // Clock edge; model applies dequeue then enqueue using pre-edge occupancy
    task automatic tick();
        bit was_full;
        @(posedge clk);
        if (rst) begin
            qa.delete(); qd.delete();
        end else begin
            was_full = qa.size() == DEPTH;
            if (qa.size() != 0 && mem_req_ready) begin
                void'(qa.pop_front()); void'(qd.pop_front());
            end
            if (mem_write && !was_full) begin
                qa.push_back(data_addr_m); qd.push_back(write_data_m);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_write = 0; mem_read = 0; data_addr_m = 0; write_data_m = 0; mem_req_ready = 0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset();
        drive(0, 0, 0, 0, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_valid", 32'(mem_req_valid), 0);
        tick();

        // Single store, one-cycle latency, then drained
        drive(1, 0, 100, 25, 1); tick();
        drive(0, 0, 0, 0, 1);
        chk("single_valid", 32'(mem_req_valid), 1);
        chk("single_addr", mem_req_addr, 100);
        chk("single_data", mem_req_data, 25);
        tick();
        drive(0, 0, 0, 0, 1);
        chk("single_empty", 32'(empty), 1);
        tick();

        // Fill and stall, then one drain lets the held store in
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(1, 0, 32'(i * 4), 32'(i + 1), 0); tick(); end
        drive(1, 0, 16, 5, 0);
        chk("fill_count", 32'(count), 4);
        chk("fill_stall", 32'(stall_m), 1);
        tick();
        drive(1, 0, 16, 5, 1);
        chk("fill_stall_drain", 32'(stall_m), 1);
        chk("fill_head", mem_req_addr, 0);
        tick();
        drive(1, 0, 16, 5, 0);
        chk("fill_unstall", 32'(stall_m), 0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("fill_count_after", 32'(count), 4);
        tick();

        // Youngest match forwarding, low address bits ignored
        do_reset();
        drive(1, 0, 96, 7, 0); tick();
        drive(1, 0, 96, 9, 0); tick();
        drive(0, 1, 96, 0, 0);
        chk("fwd96_hit", 32'(fwd_hit), 1);
        chk("fwd96_data", fwd_data, 9);
        drive(0, 1, 97, 0, 0);
        chk("fwd97_data", fwd_data, 9);
        drive(0, 1, 100, 0, 0);
        chk("fwd100_hit", 32'(fwd_hit), 0);
        tick();

        // Back-to-back stores with ready high across pointer wrap
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 32'h200 + 32'(i * 4), 32'(i), 1);
            if (i > 0) begin
                chk("wrap_count", 32'(count), 1);
                chk("wrap_addr", mem_req_addr, 32'h200 + 32'((i - 1) * 4));
            end
            tick();
        end
        drive(0, 0, 0, 0, 1); tick();

        // Backpressure holds request fields stable
        do_reset();
        drive(1, 0, 32'h44, 32'hbeef, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0);
            chk("bp_addr", mem_req_addr, 32'h44);
            chk("bp_data", mem_req_data, 32'hbeef);
            tick();
        end
        drive(0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0);
        chk("bp_one_handshake", 32'(empty), 1);
        tick();

        // Reset mid-operation discards entries
        do_reset();
        for (int i = 0; i < 3; i++) begin drive(1, 0, 32'h80 + 32'(i * 4), 32'(i + 10), 0); tick(); end
        do_reset();
        drive(0, 1, 32'h84, 0, 0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_valid", 32'(mem_req_valid), 0);
        chk("mid_rst_fwd", 32'(fwd_hit), 0);
        tick();

        // Random traffic over a small address pool
        for (int c = 0; c < 600; c++) begin
            int op;
            logic rdy;
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                op = int'($urandom_range(0, 2));
                held_a = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
                held_d = $urandom;
                rdy = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                drive(op == 1, op == 2, held_a, held_d, rdy);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
